// File: rtl/wb_stage.sv
// Write-back stage: commits register-file writes, owns CP0 and raises exception/ERET flushes.
// Optional CP0 Count/Compare timer is built when CP0_TIMER_EN is defined.
module wb_stage (
  input  logic         clk,
  input  logic         reset,
  output logic         ws_allowin,
  input  logic         ms_to_ws_valid,
  input  logic [149:0] ms_to_ws_bus,
  output logic [37:0]  ws_to_rf_bus,
  output logic [31:0]  ws_forward,
  output logic         ws_valid_h,
  output logic         ws_res_from_cp0_h,
  input  logic [5:0]   ext_int_in,
  output logic         ex_from_ws,
  output logic [31:0]  ex_target,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_wen,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata
);

  localparam logic [4:0]  CP0_BADVADDR = 5'd8;
  localparam logic [4:0]  CP0_COUNT    = 5'd9;
  localparam logic [4:0]  CP0_COMPARE  = 5'd11;
  localparam logic [4:0]  CP0_STATUS   = 5'd12;
  localparam logic [4:0]  CP0_CAUSE    = 5'd13;
  localparam logic [4:0]  CP0_EPC      = 5'd14;
  localparam logic [4:0]  EXC_INT      = 5'h00;
  localparam logic [4:0]  EXC_ADEL     = 5'h04;
  localparam logic [4:0]  EXC_ADES     = 5'h05;
  localparam logic [31:0] EX_VECTOR    = 32'hBFC0_0380;

  logic         ws_valid_q, ws_valid_d;
  logic [149:0] ws_bus_q, ws_bus_d;
  logic [31:0]  badvaddr_q, badvaddr_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  compare_q, compare_d;
  logic [7:0]   status_im_q, status_im_d;
  logic         status_exl_q, status_exl_d;
  logic         status_ie_q, status_ie_d;
  logic         cause_bd_q, cause_bd_d;
  logic         cause_ti_q, cause_ti_d;
  logic [5:0]   cause_ip_hw_q, cause_ip_hw_d;
  logic [1:0]   cause_ip_sw_q, cause_ip_sw_d;
  logic [4:0]   cause_exccode_q, cause_exccode_d;
  logic [31:0]  epc_q, epc_d;
`ifdef CP0_TIMER_EN
  logic         tick_q, tick_d;
`endif

  logic         ws_ready_go;
  logic         ws_inst_addr_ex, ws_eret, ws_bd, ws_mtc0_we, ws_res_from_cp0, ws_ex, ws_gr_we;
  logic [31:0]  ws_rt_value, ws_alu_result, ws_final_result, ws_pc;
  logic [4:0]   ws_cp0_addr, ws_excode, ws_dest;
  logic [7:0]   cause_ip;
  logic [31:0]  status_val, cause_val, cp0_rdata;
  logic         int_pending, ex_entry, eret_taken, mtc0_do, rf_we;
  logic [4:0]   eff_excode;
  logic [31:0]  rf_wdata;

  assign {ws_inst_addr_ex, ws_rt_value, ws_eret, ws_bd, ws_mtc0_we, ws_cp0_addr,
          ws_res_from_cp0, ws_alu_result, ws_ex, ws_excode, ws_gr_we, ws_dest,
          ws_final_result, ws_pc} = ws_bus_q;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid_q || ws_ready_go;

  // IP[15] carries the timer interrupt alongside hardware line 5
  assign cause_ip   = {cause_ip_hw_q[5] | cause_ti_q, cause_ip_hw_q[4:0], cause_ip_sw_q};
  assign status_val = {9'd0, 1'b1, 6'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
  assign cause_val  = {cause_bd_q, cause_ti_q, 14'd0, cause_ip, 1'b0, cause_exccode_q, 2'd0};

  assign int_pending = status_ie_q && !status_exl_q && (|(cause_ip & status_im_q));
  assign ex_entry    = ws_valid_q && (int_pending || ws_ex);
  assign eret_taken  = ws_valid_q && ws_eret && !ex_entry;
  assign ex_from_ws  = ex_entry || eret_taken;
  assign ex_target   = ex_entry ? EX_VECTOR : epc_q;
  assign eff_excode  = int_pending ? EXC_INT : ws_excode;
  assign mtc0_do     = ws_valid_q && ws_mtc0_we && !ex_from_ws;

  // mfc0 read mux
  always_comb begin
    cp0_rdata = 32'd0;
    case (ws_cp0_addr)
      CP0_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_COUNT:    cp0_rdata = count_q;
      CP0_COMPARE:  cp0_rdata = compare_q;
      CP0_STATUS:   cp0_rdata = status_val;
      CP0_CAUSE:    cp0_rdata = cause_val;
      CP0_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  assign rf_we             = ws_valid_q && ws_gr_we && !ex_from_ws;
  assign rf_wdata          = ws_res_from_cp0 ? cp0_rdata : ws_final_result;
  assign ws_to_rf_bus      = {rf_we, ws_dest, rf_wdata};
  assign ws_forward        = rf_wdata;
  assign ws_valid_h        = ws_valid_q;
  assign ws_res_from_cp0_h = ws_valid_q && ws_res_from_cp0;
  assign debug_wb_pc       = ws_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = ws_dest;
  assign debug_wb_rf_wdata = rf_wdata;

  // Pipeline handshake next state
  always_comb begin
    ws_valid_d = ws_valid_q;
    ws_bus_d   = ws_bus_q;
    if (ex_from_ws) begin
      ws_valid_d = 1'b0;
    end else if (ws_allowin) begin
      ws_valid_d = ms_to_ws_valid;
    end else begin
      ws_valid_d = ws_valid_q;
    end
    if (ms_to_ws_valid && ws_allowin) begin
      ws_bus_d = ms_to_ws_bus;
    end else begin
      ws_bus_d = ws_bus_q;
    end
  end

  // CP0 next state: exception entry, then ERET, then mtc0
  always_comb begin
    badvaddr_d      = badvaddr_q;
    status_im_d     = status_im_q;
    status_exl_d    = status_exl_q;
    status_ie_d     = status_ie_q;
    cause_bd_d      = cause_bd_q;
    cause_ip_hw_d   = ext_int_in;
    cause_ip_sw_d   = cause_ip_sw_q;
    cause_exccode_d = cause_exccode_q;
    epc_d           = epc_q;
    if (ex_entry) begin
      if (!status_exl_q) begin
        epc_d      = ws_bd ? (ws_pc - 32'd4) : ws_pc;
        cause_bd_d = ws_bd;
      end else begin
        epc_d      = epc_q;
        cause_bd_d = cause_bd_q;
      end
      status_exl_d    = 1'b1;
      cause_exccode_d = eff_excode;
      if (eff_excode == EXC_ADEL || eff_excode == EXC_ADES) begin
        badvaddr_d = ws_inst_addr_ex ? ws_pc : ws_alu_result;
      end else begin
        badvaddr_d = badvaddr_q;
      end
    end else if (eret_taken) begin
      status_exl_d = 1'b0;
    end else if (mtc0_do) begin
      case (ws_cp0_addr)
        CP0_STATUS: begin
          status_im_d  = ws_rt_value[15:8];
          status_exl_d = ws_rt_value[1];
          status_ie_d  = ws_rt_value[0];
        end
        CP0_CAUSE: cause_ip_sw_d = ws_rt_value[9:8];
        CP0_EPC:   epc_d         = ws_rt_value;
        default:   epc_d         = epc_q;
      endcase
    end else begin
      status_exl_d = status_exl_q;
    end
  end

`ifdef CP0_TIMER_EN
  // Count ticks every other cycle; Compare match latches TI until Compare is rewritten
  always_comb begin
    tick_d = ~tick_q;
    if (mtc0_do && ws_cp0_addr == CP0_COUNT) begin
      count_d = ws_rt_value;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    if (mtc0_do && ws_cp0_addr == CP0_COMPARE) begin
      compare_d  = ws_rt_value;
      cause_ti_d = 1'b0;
    end else if (compare_q != 32'd0 && count_q == compare_q) begin
      compare_d  = compare_q;
      cause_ti_d = 1'b1;
    end else begin
      compare_d  = compare_q;
      cause_ti_d = cause_ti_q;
    end
  end
`else
  // Timer absent: Count/Compare/TI stay at zero
  always_comb begin
    count_d    = 32'd0;
    compare_d  = 32'd0;
    cause_ti_d = 1'b0;
  end
`endif

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q      <= 1'b0;
      ws_bus_q        <= 150'd0;
      badvaddr_q      <= 32'd0;
      count_q         <= 32'd0;
      compare_q       <= 32'd0;
      status_im_q     <= 8'd0;
      status_exl_q    <= 1'b0;
      status_ie_q     <= 1'b0;
      cause_bd_q      <= 1'b0;
      cause_ti_q      <= 1'b0;
      cause_ip_hw_q   <= 6'd0;
      cause_ip_sw_q   <= 2'd0;
      cause_exccode_q <= 5'd0;
      epc_q           <= 32'd0;
`ifdef CP0_TIMER_EN
      tick_q          <= 1'b0;
`endif
    end else begin
      ws_valid_q      <= ws_valid_d;
      ws_bus_q        <= ws_bus_d;
      badvaddr_q      <= badvaddr_d;
      count_q         <= count_d;
      compare_q       <= compare_d;
      status_im_q     <= status_im_d;
      status_exl_q    <= status_exl_d;
      status_ie_q     <= status_ie_d;
      cause_bd_q      <= cause_bd_d;
      cause_ti_q      <= cause_ti_d;
      cause_ip_hw_q   <= cause_ip_hw_d;
      cause_ip_sw_q   <= cause_ip_sw_d;
      cause_exccode_q <= cause_exccode_d;
      epc_q           <= epc_d;
`ifdef CP0_TIMER_EN
      tick_q          <= tick_d;
`endif
    end
  end

endmodule
